// File: rtl/arm_pipe_pkg.sv
// Shared EXE->MEM pipeline types: default widths, entry layout and
// the {skid_valid, main_valid} state codes of the elastic stage.
package arm_pipe_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEST_WIDTH_DEF = 4;

    typedef struct packed {
        logic                      wb_en;
        logic                      mem_r_en;
        logic                      mem_w_en;
        logic [DATA_WIDTH_DEF-1:0] alu_result;
        logic [DATA_WIDTH_DEF-1:0] val_rm;
        logic [DEST_WIDTH_DEF-1:0] dest;
    } exe_mem_t;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: load-enabled payload register plus valid bit.
// Clear drops only the valid bit; the payload is left stale.
module pipe_entry_reg
    import arm_pipe_pkg::*;
#(
    parameter type T = exe_mem_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clear,
    input  T     i_data,
    output logic o_valid,
    output T     o_data
);

    logic r_valid;
    T     r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM elastic stage: main + skid entry, so in_ready is a flop
// (!skid_valid) and never depends combinationally on out_ready.
module exe_mem_skid_reg
    import arm_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEST_WIDTH = DEST_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] val_rm_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] val_rm,
    output logic [DEST_WIDTH-1:0] dest,
    output logic                  fwd_valid,
    output logic [DEST_WIDTH-1:0] fwd_dest,
    output logic [DATA_WIDTH-1:0] fwd_value
);

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] val_rm;
        logic [DEST_WIDTH-1:0] dest;
    } entry_t;

    entry_t     w_in, w_main, w_skid, w_main_d;
    logic       w_main_valid, w_skid_valid;
    logic       w_main_load, w_main_clr, w_skid_load, w_skid_clr;
    logic       w_in_xfer, w_out_xfer;
    logic [1:0] w_state;

    assign w_in       = '{wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in};
    assign w_state    = {w_skid_valid, w_main_valid};
    assign in_ready   = !w_skid_valid;
    assign out_valid  = w_main_valid;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_main_d    = w_in;
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (w_state)
                ST_EMPTY: w_main_load = w_in_xfer;
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) w_main_load = 1'b1;
                    else if (w_in_xfer)          w_skid_load = 1'b1;
                    else if (w_out_xfer)         w_main_clr  = 1'b1;
                end
                // FULL, and the stray 10 code: promote skid once main frees up
                default: begin
                    if (w_out_xfer || !w_main_valid) begin
                        w_main_d    = w_skid;
                        w_main_load = 1'b1;
                        w_skid_clr  = 1'b1;
                    end
                end
            endcase
        end
    end

    pipe_entry_reg #(.T(entry_t)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main)
    );

    pipe_entry_reg #(.T(entry_t)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_data  (w_in),
        .o_valid (w_skid_valid),
        .o_data  (w_skid)
    );

    // Bubbles must never write memory or the register file.
    assign wb_en      = out_valid && w_main.wb_en;
    assign mem_r_en   = out_valid && w_main.mem_r_en;
    assign mem_w_en   = out_valid && w_main.mem_w_en;
    assign alu_result = w_main.alu_result;
    assign val_rm     = w_main.val_rm;
    assign dest       = w_main.dest;

    assign fwd_valid  = wb_en;
    assign fwd_dest   = w_main.dest;
    assign fwd_value  = w_main.alu_result;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed + random bench for exe_mem_skid_reg with a FIFO scoreboard:
// held entries are modelled as a queue of at most two.
module tb_exe_mem_skid_reg;

    typedef struct packed {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] r;
        logic [3:0]  d;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
    logic [31:0] alu_result_in = '0, val_rm_in = '0;
    logic [3:0]  dest_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_result, val_rm;
    logic [3:0]  dest;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_value;

    int  n_checks = 0;
    int  n_pass   = 0;
    sb_t q[$];

    always #5 clk = ~clk;

    exe_mem_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .val_rm(val_rm), .dest(dest),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] r, input logic [3:0] d);
        in_valid = v;
        {wb_en_in, mem_r_en_in, mem_w_en_in} = c;
        alu_result_in = a;
        val_rm_in     = r;
        dest_in       = d;
    endtask

    // Check outputs against the model at negedge, then advance the model
    // and the DUT across one rising edge.
    task automatic cycle();
        sb_t e;
        bit  exp_ov, exp_ir, ox, ix;
        @(negedge clk);
        exp_ov = (q.size() > 0);
        exp_ir = (q.size() < 2);
        chk("in_ready", 128'(in_ready), 128'(exp_ir));
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        if (exp_ov) begin
            e = q[0];
            chk("main_entry", 128'({wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest}), 128'(e));
            chk("fwd_valid", 128'(fwd_valid), 128'(e.c[2]));
            chk("fwd_dest", 128'(fwd_dest), 128'(e.d));
            chk("fwd_value", 128'(fwd_value), 128'(e.a));
        end else begin
            chk("bubble_ctrl", 128'({wb_en, mem_r_en, mem_w_en}), 128'(0));
            chk("bubble_fwd", 128'(fwd_valid), 128'(0));
        end
        ox = exp_ov && out_ready;
        ix = in_valid && exp_ir;
        if (ox) void'(q.pop_front());
        if (flush) q.delete();
        else if (ix) q.push_back(sb_t'({wb_en_in, mem_r_en_in, mem_w_en_in,
                                         alu_result_in, val_rm_in, dest_in}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values are visible while rst_n is held low.
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_outputs", 128'({wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest, fwd_valid}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'(i), 32'(i * 'h11), 32'h100 + 32'(i), 4'(i));
            cycle();
        end
        drive(1'b0, 3'b0, '0, '0, '0);
        repeat (2) cycle();

        // Back-pressure: A0, B0 fill both entries; C0 is refused while full.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'hA0, 32'h1, 4'h1); cycle();
        drive(1'b1, 3'b001, 32'hB0, 32'h2, 4'h2); cycle();
        drive(1'b1, 3'b100, 32'hC0, 32'h3, 4'h3); cycle();
        chk("bp_hold_a0", 128'(alu_result), 128'(32'hA0));
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        drive(1'b0, 3'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Flush while FULL, with dest 7 offered in the flush cycle.
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 32'h1, 32'h0, 4'h5); cycle();
        drive(1'b1, 3'b100, 32'h2, 32'h0, 4'h6); cycle();
        drive(1'b1, 3'b100, 32'h3, 32'h0, 4'h7);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 3'b0, '0, '0, '0);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        repeat (2) cycle();

        // Flush in BUSY with an output transfer in the same cycle.
        out_ready = 1'b1;
        drive(1'b1, 3'b110, 32'h55, 32'h66, 4'h2); cycle();
        drive(1'b1, 3'b110, 32'h77, 32'h88, 4'h4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 3'b0, '0, '0, '0);
        cycle();

        // Bubble gating: stale mem_w_en entry left behind after drain.
        drive(1'b1, 3'b001, 32'h99, 32'hAA, 4'h9); cycle();
        drive(1'b0, 3'b0, '0, '0, '0);
        cycle();
        chk("bubble_mem_w_en", 128'(mem_w_en), 128'(0));
        chk("bubble_fwd_valid", 128'(fwd_valid), 128'(0));

        // Forwarding with wb_en set, then the same entry with wb_en clear.
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 32'hDEADBEEF, 32'h0, 4'h3); cycle();
        drive(1'b0, 3'b0, '0, '0, '0);
        cycle();
        chk("fwd_on_valid", 128'(fwd_valid), 128'(1));
        chk("fwd_on_dest", 128'(fwd_dest), 128'(3));
        chk("fwd_on_value", 128'(fwd_value), 128'(32'hDEADBEEF));
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'hDEADBEEF, 32'h0, 4'h3); cycle();
        drive(1'b0, 3'b0, '0, '0, '0);
        out_ready = 1'b0;
        cycle();
        chk("fwd_off_valid", 128'(fwd_valid), 128'(0));
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset mid-stream with both entries full.
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 32'h1234, 32'h5678, 4'hA); cycle();
        drive(1'b1, 3'b111, 32'h4321, 32'h8765, 4'hB); cycle();
        drive(1'b0, 3'b0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_outputs", 128'({wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest, fwd_valid}), 128'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  4'($urandom_range(0, 15)));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, 3'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
- Parametrised EXE→MEM pipeline register that replaces the free-running EXE stage register with a valid/ready elastic stage.
- A 2-entry skid buffer (main + skid) absorbs one cycle of MEM back-pressure without combinational ready paths.
- Supports synchronous flush for branch squash.
- Exposes the main-entry destination and result for the hazard/forwarding unit.

Parameters:
- DATA_WIDTH, 32, width of alu_result and val_rm.
- DEST_WIDTH, 4, width of the destination register index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  EXE presents a valid instruction.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits from EXE.
- alu_result_in  input  DATA_WIDTH  ALU result.
- val_rm_in  input  DATA_WIDTH  store data.
- dest_in  input  DEST_WIDTH  destination register.
- out_valid  output  1  main entry holds a valid instruction.
- out_ready  input  1  MEM accepts the main entry.
- wb_en, mem_r_en, mem_w_en  output  1 each  main-entry control, gated by out_valid.
- alu_result, val_rm  output  DATA_WIDTH  main-entry data.
- dest  output  DEST_WIDTH  main-entry destination.
- fwd_valid  output  1  out_valid & wb_en; qualifies forwarding.
- fwd_dest  output  DEST_WIDTH  equals dest.
- fwd_value  output  DATA_WIDTH  equals alu_result.

Behaviour:
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - Latency: an accepted input is visible on outputs the next cycle when the stage was EMPTY, or when it was BUSY and draining.
- Reset (rst_n low, asynchronous):
  - main_valid = skid_valid = 0; all data/control outputs = 0.
  - in_ready = 1, out_valid = 0, fwd_valid = 0.
  - Deassertion is synchronised externally; the first edge after release behaves as EMPTY.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - in transfer → BUSY, main loads input.
  - BUSY (01):
    - out transfer without in transfer → EMPTY.
    - in transfer with out transfer → BUSY, main loads input.
    - in transfer without out transfer → FULL, skid loads input, main holds.
    - Otherwise hold.
  - FULL (11):
    - in_ready = 0, so no input is accepted.
    - out transfer → BUSY, main loads skid, skid cleared.
    - Otherwise hold.
  - (10) is unreachable; if entered, it is treated as FULL.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Output gating: wb_en, mem_r_en, mem_w_en are forced 0 when out_valid = 0, so a bubble never writes memory or the register file. Data outputs keep stale values when invalid.
- Flush:
  - Takes priority over all handshakes.
  - Next cycle: main_valid = skid_valid = 0, in_ready = 1.
  - An input offered during the flush cycle is dropped even though in_ready was 1.
  - The output transfer in the flush cycle still counts for MEM, since MEM sampled it.
- Stability: while out_valid & !out_ready, all main-entry outputs hold stable.
- Reset mid-operation: both entries are discarded immediately; there is no partial drain.
- Widths: no arithmetic; fields are copied bit-exact. Control packing order is {wb_en, mem_r_en, mem_w_en}.

Decomposition:
- Shared package (arm_pipe_pkg):
  - DATA_WIDTH and DEST_WIDTH defaults.
  - Packed struct exe_mem_t {wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest}.
  - Localparams for state codes EMPTY / BUSY / FULL.
- Sub-module: pipe_entry_reg, one instance each for main and skid. It is a load-enabled, async-active-low-reset register of exe_mem_t with a valid bit and clear input. Top level holds only the control FSM and output gating.

Test Plan:
- Reset: rst_n low mid-stream with both entries full → outputs all 0, out_valid = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Streaming: out_ready = 1, in_valid = 1 for 4 cycles with alu_result_in = 0x11, 0x22, 0x33, 0x44 → same sequence on alu_result one cycle later, in_ready stays 1 throughout.
- Back-pressure:
  - Load 0xA0 then 0xB0 with out_ready = 0 → in_ready falls to 0, alu_result holds 0xA0.
  - Raise out_ready → 0xA0, then 0xB0 delivered, then in_ready = 1.
- Flush when FULL with in_valid = 1, dest_in = 7 → next cycle out_valid = 0, in_ready = 1, and dest 7 never appears.
- Bubble gating: EMPTY stage with stale mem_w_en data held → mem_w_en = 0 and fwd_valid = 0.
- Forwarding: main holds wb_en = 1, dest = 3, alu_result = 0xDEAD_BEEF → fwd_valid = 1, fwd_dest = 3, fwd_value = 0xDEADBEEF. The same entry with wb_en = 0 → fwd_valid = 0.
